// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the opcodes, FSM encoding, big-endian lane selects and small decode helpers.
package mem_lsu_pkg;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Big-endian: byte offset 0 is the most significant lane.
    localparam logic [3:0] SEL_B0 = 4'b1000;
    localparam logic [3:0] SEL_B1 = 4'b0100;
    localparam logic [3:0] SEL_B2 = 4'b0010;
    localparam logic [3:0] SEL_B3 = 4'b0001;
    localparam logic [3:0] SEL_H0 = 4'b1100;
    localparam logic [3:0] SEL_H1 = 4'b0011;
    localparam logic [3:0] SEL_W  = 4'b1111;

    function automatic logic is_mem_op(input logic [7:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear; bytes never fault.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = off[0];
            OP_LW, OP_SW:         bad = |off;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: picks the byte enables, replicates store data
// across lanes and extracts/extends the addressed part of a loaded word.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] reg2,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  lbyte;
    logic [15:0] lhalf;
    logic [3:0]  sel_b;
    logic [3:0]  sel_h;

    // Select lane and format data according to the access size and signedness.
    always_comb begin
        sel   = 4'b0000;
        wdata = 32'h0;
        ldata = 32'h0;

        case (offset)
            2'd0:    begin lbyte = rdata[31:24]; sel_b = SEL_B0; end
            2'd1:    begin lbyte = rdata[23:16]; sel_b = SEL_B1; end
            2'd2:    begin lbyte = rdata[15:8];  sel_b = SEL_B2; end
            default: begin lbyte = rdata[7:0];   sel_b = SEL_B3; end
        endcase
        lhalf = offset[1] ? rdata[15:0] : rdata[31:16];
        sel_h = offset[1] ? SEL_H1 : SEL_H0;

        case (aluop)
            OP_LB:  begin sel = sel_b; ldata = {{24{lbyte[7]}}, lbyte}; end
            OP_LBU: begin sel = sel_b; ldata = {24'h0, lbyte}; end
            OP_LH:  begin sel = sel_h; ldata = {{16{lhalf[15]}}, lhalf}; end
            OP_LHU: begin sel = sel_h; ldata = {16'h0, lhalf}; end
            OP_LW:  begin sel = SEL_W; ldata = rdata; end
            OP_SB:  begin sel = sel_b; wdata = {4{reg2[7:0]}}; end
            OP_SH:  begin sel = sel_h; wdata = {2{reg2[15:0]}}; end
            OP_SW:  begin sel = SEL_W; wdata = reg2; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: forwards ALU results to mem_wb and runs loads/stores on a
// req/ack data bus, stalling the pipeline until the access completes.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DBUS_AW = 32,
    parameter int DBUS_DW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         stall,
    input  logic [4:0]         ex_wd,
    input  logic               ex_wreg,
    input  logic [31:0]        ex_wdata,
    input  logic               ex_whilo,
    input  logic [31:0]        ex_hi,
    input  logic [31:0]        ex_lo,
    input  logic [7:0]         ex_aluop,
    input  logic [31:0]        ex_mem_addr,
    input  logic [31:0]        ex_reg2,
    output logic [4:0]         mem_wd,
    output logic               mem_wreg,
    output logic [31:0]        mem_wdata,
    output logic               mem_whilo,
    output logic [31:0]        mem_hi,
    output logic [31:0]        mem_lo,
    output logic               stallreq_mem,
    output logic               excpt_ade,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [DBUS_AW-1:0] dbus_addr,
    output logic [3:0]         dbus_sel,
    output logic [DBUS_DW-1:0] dbus_wdata,
    input  logic               dbus_ack,
    input  logic [DBUS_DW-1:0] dbus_rdata
);

    lsu_state_e  state_q, state_d;

    // Registered copy of the request so the bus stays stable while ex_* moves on.
    logic [7:0]  req_aluop_q, req_aluop_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [31:0] req_reg2_q,  req_reg2_d;
    logic [4:0]  req_wd_q,    req_wd_d;
    logic        req_wreg_q,  req_wreg_d;

    // Result presented to mem_wb while in DONE.
    logic [4:0]  cap_wd_q,    cap_wd_d;
    logic        cap_wreg_q,  cap_wreg_d;
    logic [31:0] cap_wdata_q, cap_wdata_d;

    logic        ex_is_mem, ex_misal, issue, in_wait, bus_active, accept;
    logic [7:0]  cur_aluop;
    logic [31:0] cur_addr, cur_reg2;
    logic [4:0]  cur_wd;
    logic        cur_wreg;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_ldata;

    // Only the mem_wb hold bit matters to this stage.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[3:0]};

    // Decode the incoming op and choose between live and held request fields.
    always_comb begin
        ex_is_mem  = is_mem_op(ex_aluop);
        ex_misal   = ex_is_mem && is_misaligned(ex_aluop, ex_mem_addr[1:0]);
        issue      = (state_q == ST_IDLE) && ex_is_mem && !ex_misal;
        in_wait    = (state_q == ST_WAIT);
        bus_active = issue || in_wait;
        accept     = bus_active && dbus_ack;
        cur_aluop  = in_wait ? req_aluop_q : ex_aluop;
        cur_addr   = in_wait ? req_addr_q  : ex_mem_addr;
        cur_reg2   = in_wait ? req_reg2_q  : ex_reg2;
        cur_wd     = in_wait ? req_wd_q    : ex_wd;
        cur_wreg   = in_wait ? req_wreg_q  : ex_wreg;
    end

    mem_lsu_align u_align (
        .aluop  (cur_aluop),
        .offset (cur_addr[1:0]),
        .rdata  (dbus_rdata[31:0]),
        .reg2   (cur_reg2),
        .sel    (al_sel),
        .wdata  (al_wdata),
        .ldata  (al_ldata)
    );

    // Next-state, request-copy and capture logic.
    always_comb begin
        state_d     = state_q;
        req_aluop_d = req_aluop_q;
        req_addr_d  = req_addr_q;
        req_reg2_d  = req_reg2_q;
        req_wd_d    = req_wd_q;
        req_wreg_d  = req_wreg_q;
        cap_wd_d    = cap_wd_q;
        cap_wreg_d  = cap_wreg_q;
        cap_wdata_d = cap_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    req_aluop_d = ex_aluop;
                    req_addr_d  = ex_mem_addr;
                    req_reg2_d  = ex_reg2;
                    req_wd_d    = ex_wd;
                    req_wreg_d  = ex_wreg;
                    state_d     = dbus_ack ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dbus_ack) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!stall[4]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            cap_wd_d    = cur_wd;
            cap_wreg_d  = is_store(cur_aluop) ? 1'b0 : cur_wreg;
            cap_wdata_d = is_store(cur_aluop) ? 32'h0 : al_ldata;
        end
    end

    // Output steering; everything is forced low while reset is asserted.
    always_comb begin
        mem_wd       = 5'd0;
        mem_wreg     = 1'b0;
        mem_wdata    = 32'h0;
        mem_whilo    = 1'b0;
        mem_hi       = 32'h0;
        mem_lo       = 32'h0;
        stallreq_mem = 1'b0;
        excpt_ade    = 1'b0;
        dbus_req     = 1'b0;
        dbus_we      = 1'b0;
        dbus_addr    = '0;
        dbus_sel     = 4'b0000;
        dbus_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                // Memory ops (issued or faulting) must not write back this cycle.
                mem_wd       = ex_wd;
                mem_wreg     = ex_is_mem ? 1'b0 : ex_wreg;
                mem_wdata    = ex_wdata;
                mem_whilo    = ex_is_mem ? 1'b0 : ex_whilo;
                mem_hi       = ex_hi;
                mem_lo       = ex_lo;
                excpt_ade    = ex_misal;
                stallreq_mem = issue;
                dbus_req     = issue;
            end
            ST_WAIT: begin
                stallreq_mem = 1'b1;
                dbus_req     = 1'b1;
            end
            ST_DONE: begin
                mem_wd    = cap_wd_q;
                mem_wreg  = cap_wreg_q;
                mem_wdata = cap_wdata_q;
            end
            default: ;
        endcase

        if (bus_active) begin
            dbus_we    = is_store(cur_aluop);
            dbus_addr  = {cur_addr[DBUS_AW-1:2], 2'b00};
            dbus_sel   = al_sel;
            dbus_wdata = al_wdata;
        end

        if (!rst) begin
            mem_wd       = 5'd0;
            mem_wreg     = 1'b0;
            mem_wdata    = 32'h0;
            mem_whilo    = 1'b0;
            mem_hi       = 32'h0;
            mem_lo       = 32'h0;
            stallreq_mem = 1'b0;
            excpt_ade    = 1'b0;
            dbus_req     = 1'b0;
            dbus_we      = 1'b0;
            dbus_addr    = '0;
            dbus_sel     = 4'b0000;
            dbus_wdata   = '0;
        end
    end

    // FSM state and capture register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cap_wd_q    <= 5'd0;
            cap_wreg_q  <= 1'b0;
            cap_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cap_wd_q    <= cap_wd_d;
            cap_wreg_q  <= cap_wreg_d;
            cap_wdata_q <= cap_wdata_d;
        end
    end

    // Request copy is only consumed in WAIT, which is always entered after a load of it.
    always_ff @(posedge clk) begin
        req_aluop_q <= req_aluop_d;
        req_addr_q  <= req_addr_d;
        req_reg2_q  <= req_reg2_d;
        req_wd_q    <= req_wd_d;
        req_wreg_q  <= req_wreg_d;
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stimulus pushes expected bus transfers and
// completions into queues; a monitor pops and compares when the DUT shows them.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_reg2;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        stallreq_mem;
    logic        excpt_ade;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_whilo     (ex_whilo),
        .ex_hi        (ex_hi),
        .ex_lo        (ex_lo),
        .ex_aluop     (ex_aluop),
        .ex_mem_addr  (ex_mem_addr),
        .ex_reg2      (ex_reg2),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_whilo    (mem_whilo),
        .mem_hi       (mem_hi),
        .mem_lo       (mem_lo),
        .stallreq_mem (stallreq_mem),
        .excpt_ade    (excpt_ade),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_sel     (dbus_sel),
        .dbus_wdata   (dbus_wdata),
        .dbus_ack     (dbus_ack),
        .dbus_rdata   (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_data;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    bus_exp_t  be;
    done_exp_t de;

    int checks = 0;
    int errors = 0;
    logic prev_stallreq = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nonmem(input logic [4:0] wd, input logic [31:0] wdata);
        ex_aluop    = 8'h21;
        ex_wd       = wd;
        ex_wreg     = 1'b1;
        ex_wdata    = wdata;
        ex_whilo    = 1'b1;
        ex_hi       = 32'hA0A0A0A0;
        ex_lo       = 32'h0B0B0B0B;
        ex_mem_addr = 32'h0;
        ex_reg2     = 32'h0;
    endtask

    // Monitor: compares bus transfers on ack and results on the first DONE cycle.
    always @(negedge clk) begin
        if (rst && dbus_req && dbus_ack) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected actual=%h required=none", dbus_addr);
            end else begin
                be = bus_q.pop_front();
                check("bus_we", {31'h0, dbus_we}, {31'h0, be.we});
                check("bus_addr", dbus_addr, be.addr);
                check("bus_sel", {28'h0, dbus_sel}, {28'h0, be.sel});
                if (be.chk_wdata) check("bus_wdata", dbus_wdata, be.wdata);
            end
        end
        if (rst && prev_stallreq && !stallreq_mem) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected actual=%h required=none", mem_wdata);
            end else begin
                de = done_q.pop_front();
                check("done_wd", {27'h0, mem_wd}, {27'h0, de.wd});
                check("done_wreg", {31'h0, mem_wreg}, {31'h0, de.wreg});
                if (de.chk_data) check("done_wdata", mem_wdata, de.wdata);
            end
        end
        prev_stallreq = stallreq_mem;
    end

    // One memory access: lat request cycles (ack on the last), then hold+1 DONE cycles.
    task automatic do_mem(input string name, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] rdata, input int lat, input int hold,
                          input logic exp_we, input logic [31:0] exp_addr, input logic [3:0] exp_sel,
                          input logic [31:0] exp_bwdata, input logic chk_bw,
                          input logic exp_wreg, input logic [31:0] exp_data, input logic chk_data);
        bus_exp_t  b;
        done_exp_t d;
        int reqcnt;
        int stcnt;
        b.we = exp_we; b.addr = exp_addr; b.sel = exp_sel; b.wdata = exp_bwdata; b.chk_wdata = chk_bw;
        d.wd = wd; d.wreg = exp_wreg; d.wdata = exp_data; d.chk_data = chk_data;
        bus_q.push_back(b);
        done_q.push_back(d);
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wd = wd; ex_wreg = wreg;
        ex_wdata = 32'h0BAD0BAD; ex_whilo = 1'b0;
        reqcnt = 0;
        stcnt  = 0;
        for (int i = 0; i < lat; i++) begin
            dbus_ack   = (i == lat - 1);
            dbus_rdata = (i == lat - 1) ? rdata : 32'hDEADDEAD;
            @(negedge clk);
            if (i == 0) check({name, "_ade"}, {31'h0, excpt_ade}, 32'h0);
            reqcnt += int'(dbus_req);
            stcnt  += int'(stallreq_mem);
            cyc();
            // Upstream may move on while the access is outstanding.
            ex_aluop = 8'h00; ex_mem_addr = 32'hFFFFFFF1; ex_reg2 = 32'h0; ex_wd = 5'd31;
        end
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h55AA55AA;
        check({name, "_req_cycles"}, reqcnt, lat);
        check({name, "_stall_cycles"}, stcnt, lat);
        for (int h = 0; h <= hold; h++) begin
            stall = (h < hold) ? 6'b010000 : 6'b000000;
            @(negedge clk);
            check({name, "_done_req"}, {31'h0, dbus_req}, 32'h0);
            check({name, "_done_stallreq"}, {31'h0, stallreq_mem}, 32'h0);
            if (h > 0) begin
                check({name, "_hold_wreg"}, {31'h0, mem_wreg}, {31'h0, exp_wreg});
                if (chk_data) check({name, "_hold_wdata"}, mem_wdata, exp_data);
            end
            cyc();
        end
        stall = 6'b000000;
        set_nonmem(5'd0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        stall = 6'b0;
        dbus_ack = 1'b0;
        dbus_rdata = 32'h0;
        set_nonmem(5'd9, 32'h11112222);
        repeat (2) @(posedge clk);
        #1;

        // Reset: outputs forced to zero even for pass-through and memory ops.
        @(negedge clk);
        check("rst_mem_wd", {27'h0, mem_wd}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_hi", mem_hi, 32'h0);
        check("rst_mem_wreg", {31'h0, mem_wreg}, 32'h0);
        cyc();
        ex_aluop = 8'hE3; ex_mem_addr = 32'h100;
        @(negedge clk);
        check("rst_dbus_req", {31'h0, dbus_req}, 32'h0);
        check("rst_stallreq", {31'h0, stallreq_mem}, 32'h0);
        cyc();
        rst = 1'b1;
        set_nonmem(5'd9, 32'h11112222);

        // Non-memory op passes straight through.
        @(negedge clk);
        check("pass_wd", {27'h0, mem_wd}, 32'd9);
        check("pass_wdata", mem_wdata, 32'h11112222);
        check("pass_whilo", {31'h0, mem_whilo}, 32'h1);
        check("pass_lo", mem_lo, 32'h0B0B0B0B);
        check("pass_req", {31'h0, dbus_req}, 32'h0);
        cyc();

        do_mem("lw3",  8'hE3, 32'h100, 32'h0, 5'd5, 1'b1, 32'h12345678, 3, 0,
               1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1);
        do_mem("lb",   8'hE0, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0011F022, 1, 0,
               1'b0, 32'h100, 4'b0010, 32'h0, 1'b0, 1'b1, 32'hFFFFFFF0, 1'b1);
        do_mem("lbu",  8'hE4, 32'h102, 32'h0, 5'd7, 1'b1, 32'h0011F022, 2, 0,
               1'b0, 32'h100, 4'b0010, 32'h0, 1'b0, 1'b1, 32'h000000F0, 1'b1);
        do_mem("lb0",  8'hE0, 32'h100, 32'h0, 5'd8, 1'b1, 32'h7F000000, 1, 0,
               1'b0, 32'h100, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000007F, 1'b1);
        do_mem("lbu3", 8'hE4, 32'h103, 32'h0, 5'd9, 1'b1, 32'h00000080, 1, 0,
               1'b0, 32'h100, 4'b0001, 32'h0, 1'b0, 1'b1, 32'h00000080, 1'b1);
        do_mem("lh",   8'hE1, 32'h100, 32'h0, 5'd10, 1'b1, 32'h80017FFF, 1, 0,
               1'b0, 32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF8001, 1'b1);
        do_mem("lhu",  8'hE5, 32'h102, 32'h0, 5'd11, 1'b1, 32'h8001F00D, 2, 0,
               1'b0, 32'h100, 4'b0011, 32'h0, 1'b0, 1'b1, 32'h0000F00D, 1'b1);
        do_mem("sh",   8'hE9, 32'h206, 32'hAAAA5A5A, 5'd3, 1'b1, 32'h0, 2, 0,
               1'b1, 32'h204, 4'b0011, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0, 1'b0);
        do_mem("sb",   8'hE8, 32'h301, 32'h123456A5, 5'd4, 1'b1, 32'h0, 1, 0,
               1'b1, 32'h300, 4'b0100, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0);
        do_mem("sw",   8'hEB, 32'h400, 32'hDEADBEEF, 5'd2, 1'b0, 32'h0, 3, 0,
               1'b1, 32'h400, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b0);

        // DONE held by stall[4] for two cycles, then released.
        do_mem("hold", 8'hE3, 32'h108, 32'h0, 5'd12, 1'b1, 32'hCAFEBABE, 1, 2,
               1'b0, 32'h108, 4'hF, 32'h0, 1'b0, 1'b1, 32'hCAFEBABE, 1'b1);
        set_nonmem(5'd4, 32'h13572468);
        @(negedge clk);
        check("hold_idle_wdata", mem_wdata, 32'h13572468);
        check("hold_idle_req", {31'h0, dbus_req}, 32'h0);
        cyc();

        // Misaligned accesses fault without touching the bus.
        ex_aluop = 8'hE3; ex_mem_addr = 32'h103; ex_wd = 5'd5; ex_wreg = 1'b1;
        @(negedge clk);
        check("lw_mis_ade", {31'h0, excpt_ade}, 32'h1);
        check("lw_mis_req", {31'h0, dbus_req}, 32'h0);
        check("lw_mis_stallreq", {31'h0, stallreq_mem}, 32'h0);
        check("lw_mis_wreg", {31'h0, mem_wreg}, 32'h0);
        cyc();
        ex_aluop = 8'hE1; ex_mem_addr = 32'h101;
        @(negedge clk);
        check("lh_mis_ade", {31'h0, excpt_ade}, 32'h1);
        check("lh_mis_req", {31'h0, dbus_req}, 32'h0);
        cyc();
        ex_aluop = 8'hEB; ex_mem_addr = 32'h402; ex_whilo = 1'b1;
        @(negedge clk);
        check("sw_mis_ade", {31'h0, excpt_ade}, 32'h1);
        check("sw_mis_whilo", {31'h0, mem_whilo}, 32'h0);
        cyc();
        set_nonmem(5'd13, 32'h0F0F0F0F);
        @(negedge clk);
        check("mis_after_wd", {27'h0, mem_wd}, 32'd13);
        check("mis_after_ade", {31'h0, excpt_ade}, 32'h0);
        cyc();

        // Reset while waiting: request drops at once and a late ack is ignored.
        ex_aluop = 8'hE3; ex_mem_addr = 32'h500; ex_wd = 5'd6; ex_wreg = 1'b1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rw_req0", {31'h0, dbus_req}, 32'h1);
        cyc();
        @(negedge clk);
        check("rw_wait_req", {31'h0, dbus_req}, 32'h1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rw_rst_req", {31'h0, dbus_req}, 32'h0);
        check("rw_rst_stallreq", {31'h0, stallreq_mem}, 32'h0);
        check("rw_rst_wd", {27'h0, mem_wd}, 32'h0);
        cyc();
        rst = 1'b1;
        set_nonmem(5'd8, 32'h24681357);
        dbus_ack = 1'b1;
        dbus_rdata = 32'h99999999;
        @(negedge clk);
        check("rw_late_req", {31'h0, dbus_req}, 32'h0);
        check("rw_late_stallreq", {31'h0, stallreq_mem}, 32'h0);
        check("rw_late_wdata", mem_wdata, 32'h24681357);
        cyc();
        dbus_ack = 1'b0;
        @(negedge clk);
        check("rw_nodone_wdata", mem_wdata, 32'h24681357);
        check("rw_nodone_wd", {27'h0, mem_wd}, 32'd8);
        cyc();

        check("bus_q_empty", bus_q.size(), 32'h0);
        check("done_q_empty", done_q.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
